// File: rtl/charge_port_scheduler_pkg.sv
// charge_port_scheduler_pkg
// Shared constants and types for the charging-port scheduler and the
// charge controller that feeds it.
//   - port-state encoding (IDLE / WAIT / CHARGE)
//   - port count, simultaneous-power budget, remaining-time width
//   - system clock rate and the matching 1 s divider constant
package charge_port_scheduler_pkg;

   localparam int NUM_PORTS   = 4;
   localparam int PORT_W      = 2;
   localparam int MAX_ACTIVE  = 2;
   localparam int TIME_W      = 6;
   localparam int CLK_HZ      = 1000;
   localparam int NUM_DIV_1HZ = CLK_HZ;

   typedef logic [1:0] port_state_t;

   localparam port_state_t ST_IDLE   = 2'd0;
   localparam port_state_t ST_WAIT   = 2'd1;
   localparam port_state_t ST_CHARGE = 2'd2;

endpackage

// File: rtl/charge_port_scheduler_if.sv
// charge_port_scheduler_if
// Bundles the session-request, cancel, display and power signals between
// the charge controller (master) and the scheduler (slave).
//
// Handshake: req_valid is a one-cycle pulse carrying req_port/req_time.
// There is no back-pressure; the slave answers every pulse with exactly one
// registered pulse on req_accept or req_reject in the following cycle.
// cancel_valid is a one-cycle fire-and-forget pulse.
//
// Signals:
//   req_valid/req_port/req_time   new paid session
//   cancel_valid/cancel_port      abort session
//   rd_port                       port selected for readback
//   req_accept/req_reject         response pulses
//   power_en/done_pulse           per-port power switch / end-of-charge
//   active_count                  ports currently charging
//   rd_state/rd_time              state and remaining seconds of rd_port
//   state_dbg                     all port states, 2 bits per port
interface charge_port_scheduler_if;
   import charge_port_scheduler_pkg::*;

   logic                   req_valid;
   logic [PORT_W-1:0]      req_port;
   logic [TIME_W-1:0]      req_time;
   logic                   cancel_valid;
   logic [PORT_W-1:0]      cancel_port;
   logic [PORT_W-1:0]      rd_port;
   logic                   req_accept;
   logic                   req_reject;
   logic [NUM_PORTS-1:0]   power_en;
   logic [NUM_PORTS-1:0]   done_pulse;
   logic [1:0]             active_count;
   logic [1:0]             rd_state;
   logic [TIME_W-1:0]      rd_time;
   logic [2*NUM_PORTS-1:0] state_dbg;

   modport master (
      output req_valid, req_port, req_time, cancel_valid, cancel_port, rd_port,
      input  req_accept, req_reject, power_en, done_pulse, active_count,
             rd_state, rd_time, state_dbg
   );

   modport slave (
      input  req_valid, req_port, req_time, cancel_valid, cancel_port, rd_port,
      output req_accept, req_reject, power_en, done_pulse, active_count,
             rd_state, rd_time, state_dbg
   );

endinterface

// File: rtl/charge_port_scheduler_tick_divider.sv
// charge_port_scheduler_tick_divider
// Free-running divider producing a one-cycle tick every NUM_DIV clocks.
// The count runs 0..NUM_DIV-1; tick is high while the count is NUM_DIV-1.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active-high; clears the count
//   tick   one-cycle pulse
module charge_port_scheduler_tick_divider #(
   parameter int NUM_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/charge_port_scheduler.sv
// charge_port_scheduler
// Queues paid charging sessions, powers at most MAX_ACTIVE ports at once in
// round-robin order, counts each active session down at 1 Hz and reports
// per-port status.
// Ports:
//   clk    system clock (CLK_HZ)
//   rst_n  synchronous reset, active-high despite the name
//   bus    charge_port_scheduler_if.slave (requests, cancels, status)
module charge_port_scheduler
   import charge_port_scheduler_pkg::*;
#(
   parameter int NUM_DIV = NUM_DIV_1HZ
) (
   input  logic                     clk,
   input  logic                     rst_n,
   charge_port_scheduler_if.slave   bus
);

   localparam logic [2:0] MAX_ACT = 3'(MAX_ACTIVE);

   port_state_t          st_q [NUM_PORTS];
   port_state_t          st_d [NUM_PORTS];
   logic [TIME_W-1:0]    tm_q [NUM_PORTS];
   logic [TIME_W-1:0]    tm_d [NUM_PORTS];
   logic [PORT_W-1:0]    ptr_q;
   logic [PORT_W-1:0]    ptr_d;
   logic [NUM_PORTS-1:0] done_q;
   logic [NUM_PORTS-1:0] done_d;
   logic                 acc_q;
   logic                 rej_q;

   logic                 tick;
   logic                 accept;
   logic [NUM_PORTS-1:0] charging;
   logic [NUM_PORTS-1:0] waiting;
   logic [NUM_PORTS-1:0] cancel_hit;
   logic [NUM_PORTS-1:0] eligible;
   logic [2:0]           n_charge;
   logic                 grant_vld;
   logic [PORT_W-1:0]    grant_idx;
   logic [PORT_W-1:0]    idx;

   charge_port_scheduler_tick_divider #(.NUM_DIV(NUM_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Start-of-cycle classification; a cancel only matters on a busy port.
   always_comb begin
      charging   = '0;
      waiting    = '0;
      cancel_hit = '0;
      eligible   = '0;
      n_charge   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         charging[i]   = (st_q[i] == ST_CHARGE);
         waiting[i]    = (st_q[i] == ST_WAIT);
         cancel_hit[i] = bus.cancel_valid && (bus.cancel_port == PORT_W'(i)) &&
                         (st_q[i] != ST_IDLE);
         // A port being cancelled this cycle must not consume the grant.
         eligible[i]   = waiting[i] && !cancel_hit[i];
         n_charge      = n_charge + {2'b00, charging[i]};
      end
   end

   // A cancel aimed at the requested port blocks the request even when that
   // port is idle (the cancel itself is then a no-op).
   always_comb begin
      accept = bus.req_valid && (st_q[bus.req_port] == ST_IDLE) &&
               (bus.req_time != '0) &&
               !(bus.cancel_valid && (bus.cancel_port == bus.req_port));
   end

   // Round-robin search from the pointer; index wraps naturally because
   // NUM_PORTS is a power of two. Slots freed this cycle are not yet seen.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = ptr_q + PORT_W'(k);
         if (!grant_vld && eligible[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
      if (n_charge >= MAX_ACT) begin
         grant_vld = 1'b0;
      end
      ptr_d = grant_vld ? (grant_idx + PORT_W'(1)) : ptr_q;
   end

   // Per-port next state; priority: cancel > countdown > grant > request.
   always_comb begin
      done_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         st_d[i] = st_q[i];
         tm_d[i] = tm_q[i];
         if (cancel_hit[i]) begin
            st_d[i] = ST_IDLE;
            tm_d[i] = '0;
         end else if (charging[i]) begin
            if (tick && (tm_q[i] != '0)) begin
               tm_d[i] = tm_q[i] - TIME_W'(1);
               if (tm_q[i] == TIME_W'(1)) begin
                  st_d[i]   = ST_IDLE;
                  done_d[i] = 1'b1;
               end
            end
         end else if (waiting[i]) begin
            if (grant_vld && (grant_idx == PORT_W'(i))) begin
               st_d[i] = ST_CHARGE;
            end
         end else if (st_q[i] != ST_IDLE) begin
            // Unused encoding: recover to a clean idle port.
            st_d[i] = ST_IDLE;
            tm_d[i] = '0;
         end else if (accept && (bus.req_port == PORT_W'(i))) begin
            st_d[i] = ST_WAIT;
            tm_d[i] = bus.req_time;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            st_q[i] <= ST_IDLE;
            tm_q[i] <= '0;
         end
         ptr_q  <= '0;
         done_q <= '0;
         acc_q  <= 1'b0;
         rej_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            st_q[i] <= st_d[i];
            tm_q[i] <= tm_d[i];
         end
         ptr_q  <= ptr_d;
         done_q <= done_d;
         acc_q  <= accept;
         rej_q  <= bus.req_valid && !accept;
      end
   end

   always_comb begin
      bus.state_dbg = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         bus.state_dbg[2*i +: 2] = st_q[i];
      end
   end

   assign bus.req_accept   = acc_q;
   assign bus.req_reject   = rej_q;
   assign bus.power_en     = charging;
   assign bus.done_pulse   = done_q;
   assign bus.active_count = n_charge[1:0];
   assign bus.rd_state     = st_q[bus.rd_port];
   assign bus.rd_time      = tm_q[bus.rd_port];

endmodule

// File: doc/charge_port_scheduler.md
Name: charge_port_scheduler

Overview:
Shares a limited charging-power budget among NUM_PORTS charging sockets. The charge controller hands over paid sessions as (port, seconds) requests. This block queues them, grants power to at most MAX_ACTIVE ports at once in round-robin order, counts down each active session at 1 Hz, and reports per-port status for display and end-of-charge signalling.

Parameters:
NUM_PORTS, 4, number of charging sockets (port index width 2)
MAX_ACTIVE, 2, maximum ports powered simultaneously (1..NUM_PORTS)
NUM_DIV, 1000, clk cycles per 1 s tick (1000 Hz system clock)
TIME_W, 6, remaining-time width in seconds (max 63, matches 2 s per unit of money, 20 max)

Ports:
clk  in  1  system clock, 1000 Hz
rst_n  in  1  reset; synchronous, active-high despite the name
req_valid  in  1  one-cycle pulse: new paid session
req_port  in  2  target port for req_valid
req_time  in  6  session length in seconds
cancel_valid  in  1  one-cycle pulse: abort session on cancel_port
cancel_port  in  2  target port for cancel_valid
rd_port  in  2  port selected for display readback
req_accept  out  1  registered pulse: previous-cycle request accepted
req_reject  out  1  registered pulse: previous-cycle request rejected
power_en  out  4  per-port power switch, bit i = port i
done_pulse  out  4  one-cycle pulse per port when a session times out
active_count  out  2  number of ports in CHARGE
rd_state  out  2  state of rd_port: 0 IDLE, 1 WAIT, 2 CHARGE
rd_time  out  6  remaining seconds of rd_port (combinational mux of registers)

Behaviour:
- Reset (rst_n=1 at a clk edge): all ports go to IDLE with time 0. power_en=0, done_pulse=0, req_accept/req_reject=0, active_count=0. The round-robin pointer is 0 and the tick divider counter is 0. Reset mid-session drops power on the next edge.
- Tick: the divider counts 0..NUM_DIV-1. tick is asserted for the one cycle where the count is NUM_DIV-1, then the count wraps to 0.
- Per-port FSM: IDLE -> WAIT on an accepted request, with time loaded = req_time. WAIT -> CHARGE on grant. CHARGE -> IDLE when time reaches 0 or on cancel. WAIT -> IDLE on cancel. Cancel clears time to 0.
- Request acceptance: a request is accepted iff the port is IDLE, req_time != 0, and no cancel targets the same port that cycle. Otherwise it is rejected and no state changes. The accept/reject pulse appears on the edge after sampling.
- Grant: evaluated every cycle using the state at the start of the cycle. If active_count < MAX_ACTIVE and any port is in WAIT, exactly one port is granted per cycle. The search starts at the pointer, ascending with wrap. The pointer then moves to granted port + 1 (mod NUM_PORTS).
- Grant latency: request sampled at edge k, WAIT at edge k+1, power_en=1 at edge k+2 if a slot is free.
- Countdown: on tick, every port in CHARGE at the start of that cycle decrements by 1. A port granted in the same cycle is not decremented.
  - 1 -> 0 transition: the port goes to IDLE, power_en clears and done_pulse is set, both at the same edge.
  - done_pulse clears the following cycle.
- Freed slots: a slot freed by timeout or cancel becomes available to the grant logic in the following cycle.
- Simultaneous events on one port: cancel beats tick, grant and request. A cancel on an IDLE port is ignored.
- Width rules: time is unsigned TIME_W bits and never decrements below 0. active_count equals the popcount of ports in CHARGE and never exceeds MAX_ACTIVE.

Decomposition:
- Shared package: port-state encoding (IDLE/WAIT/CHARGE), TIME_W, and the 1000 Hz clock / NUM_DIV constant shared with the charge controller divider.
- One natural sub-module, tick_divider: parameter NUM_DIV, outputs the 1-cycle tick, reset clears the count. The charge controller can reuse it.
- The round-robin grant stays inline in the scheduler.

Test Plan (NUM_DIV=4 for simulation):
- Single session: req port1 time 3. Required: req_accept, then power_en=0010 two cycles after the request. done_pulse[1] arrives after the 3rd tick; power_en=0000 on that same edge.
- Budget limit: requests on ports 0,1,2, each time 5, on consecutive cycles. Required: power_en reaches 0011 and active_count=2; port2 stays WAIT. When port0 finishes, power_en=0110 one cycle after done_pulse[0].
- Round-robin: pointer at 2, ports 0 and 3 waiting, one slot free. Required: port3 granted first, then port0 once a slot frees.
- Rejects: req on port in CHARGE -> req_reject, no time change. req_time=0 on IDLE port -> req_reject.
- Cancel races: cancel and tick in the same cycle on a CHARGE port with time 1 -> port IDLE, no done_pulse. Cancel plus request on the same IDLE port -> req_reject, port stays IDLE.
- Reset mid-operation: rst_n=1 with two ports charging -> next edge power_en=0000, all rd_time=0, and the divider restarts, so the next tick comes NUM_DIV cycles after release.
